// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer
//
// Purpose
//   A small circular instruction queue between the fetch and decode stages.
//   Fetch pushes {pc, instr} pairs and decode pops them in the same order.
//   A flush on a taken branch or jump discards every buffered entry.
//
// Configuration
//   FETCH_BUF_BYPASS_EN (macro, undefined by default)
//     When defined, an instruction that arrives while the buffer is empty is
//     shown on pop_* in the same cycle. If decode takes it in that cycle, it
//     is never stored. When undefined, every entry goes through storage and
//     appears on pop_* one cycle after the edge that accepts it.
//
// Parameters
//   DEPTH       number of entries; a power of two in the range 2..16
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   reset       synchronous, active-high reset
//   push_valid  fetch presents an instruction this cycle
//   push_pc     PC of the presented instruction
//   push_instr  presented instruction word
//   push_ready  buffer accepts a push this cycle (PC register write enable)
//   pop_valid   head entry is valid for decode
//   pop_ready   decode consumes the head entry this cycle
//   pop_pc      PC of the head entry, zero when pop_valid is low
//   pop_instr   instruction of the head entry, zero (nop) when pop_valid is low
//   flush       redirect: discard all entries and ignore this cycle's push/pop
//   count       number of valid entries
// ============================================================================
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_instr,
    output logic                     push_ready,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [31:0]              pop_pc,
    output logic [31:0]              pop_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage. It is never reset: the pointers and count alone decide
    // which entries are live.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic head_valid;   // at least one stored entry
    logic bypass_hit;   // incoming instruction shown directly on pop_*
    logic push_fire;    // handshake completes on the push side
    logic pop_fire;     // handshake completes on the pop side
    logic store_en;     // push is written into storage
    logic deq_en;       // stored head entry is removed

    // ------------------------------------------------------------------
    // Output and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        head_valid = (count_q != '0);

        // Full means not ready, even if a pop happens in the same cycle.
        // There is no full pass-through, so push_ready depends only on count.
        push_ready = (count_q != FULL_CNT);

`ifdef FETCH_BUF_BYPASS_EN
        bypass_hit = (count_q == '0) && push_valid && !flush;
`else
        bypass_hit = 1'b0;
`endif

        pop_valid = head_valid || bypass_hit;

        // The head is chosen from state and push_* only. It never depends on
        // pop_ready. Idle outputs are forced to zero so decode sees a nop.
        if (head_valid) begin
            pop_pc    = pc_mem[rd_ptr_q];
            pop_instr = instr_mem[rd_ptr_q];
        end else if (bypass_hit) begin
            pop_pc    = push_pc;
            pop_instr = push_instr;
        end else begin
            pop_pc    = 32'h0000_0000;
            pop_instr = 32'h0000_0000;
        end

        push_fire = push_valid && push_ready && !flush;
        pop_fire  = pop_valid && pop_ready && !flush;

        // If a bypassed instruction is consumed in its arrival cycle, it never
        // touches storage. Otherwise it is stored like any other push.
        store_en = push_fire && !(bypass_hit && pop_ready);
        deq_en   = pop_fire && head_valid;

        count = count_q;
    end

    // ------------------------------------------------------------------
    // Next-state: pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps DEPTH-1 to 0.
            if (store_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({store_en, deq_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state (reset applies here only)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------
    // A write during a reset cycle does no harm, because the count is cleared
    // and the slot will be overwritten before it is read again.
    always_ff @(posedge clk) begin
        if (store_en) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
        end
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 push_valid  input  1  fetch stage presents a fetched instruction this cycle.
REQ-005 push_pc  input  32  PC of the presented instruction.
REQ-006 push_instr  input  32  presented instruction word.
REQ-007 push_ready  output  1  buffer accepts a push this cycle; drives the PC register write enable.
REQ-008 pop_valid  output  1  head entry valid for decode.
REQ-009 pop_ready  input  1  decode consumes the head entry this cycle.
REQ-010 pop_pc  output  32  PC of head entry.
REQ-011 pop_instr  output  32  instruction word of head entry.
REQ-012 flush  input  1  redirect (branch/jump taken); discard all buffered entries.
REQ-013 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 Circular buffer: read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count held in its own register.
REQ-015 Push occurs when push_valid && push_ready && !flush; entry {push_pc, push_instr} is written at the write pointer, which then advances by 1.
REQ-016 Pop occurs when pop_valid && pop_ready && !flush; the read pointer advances by 1.
REQ-017 push_ready = (count != DEPTH); when full, push_ready = 0 even if a pop occurs in the same cycle (no full pass-through).
REQ-018 pop_valid = (count != 0); pop_pc/pop_instr show the head entry with no combinational dependence on pop_ready.
REQ-019 When pop_valid = 0, pop_instr = 32'h0000_0000 (nop) and pop_pc = 32'h0000_0000.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-021 Latency: a push into an empty buffer appears at pop_* one cycle later (pop_valid = 1 on the cycle after the accepting edge).
REQ-022 Entries leave in push order; no entry is duplicated or dropped except by flush or reset.
REQ-023 Flush: on the next edge count = 0 and both pointers = 0; a push or pop in the flush cycle is discarded; push_ready keeps its pre-flush value during the flush cycle.
REQ-024 Pop with count = 0 or push with count = DEPTH SHALL change no state.

Reset
REQ-025 On reset at posedge clk: count = 0, read and write pointers = 0, pop_valid = 0, push_ready = 1, pop_pc = 0, pop_instr = 0.
REQ-026 Reset takes priority over flush, push and pop in the same cycle; entry storage need not be cleared.
REQ-027 Reset asserted mid-stream SHALL discard all entries; the first push after reset deasserts is the first entry popped.

Configuration
REQ-028 Macro FETCH_BUF_BYPASS_EN: when defined, if count = 0 and push_valid && !flush, then pop_valid = 1 and pop_pc/pop_instr = push_pc/push_instr combinationally in the same cycle; if pop_ready is also 1, the instruction is consumed and not stored (count stays 0), otherwise it is stored normally.
REQ-029 When FETCH_BUF_BYPASS_EN is undefined, no bypass path exists and REQ-021 latency applies.

Verification
REQ-030 Reset, then push PCs 0x3000, 0x3004, 0x3008, 0x300C with pop_ready = 0 -> count = 4, push_ready = 0; push 0x3010 ignored; pop 4 times -> PCs 0x3000..0x300C in order, then pop_valid = 0, pop_instr = 0.
REQ-031 With count = 2, push and pop every cycle for 10 cycles (PCs 0x3000 + 4n) -> count stays 2, popped PCs strictly sequential across pointer wrap.
REQ-032 With count = 3, assert flush together with push_valid and pop_ready -> next cycle count = 0, pop_valid = 0; the pushed instruction never appears.
REQ-033 Fill to count = 4, then assert reset with push_valid = 1 -> next cycle count = 0, push_ready = 1, pop_valid = 0.
REQ-034 Empty buffer, push 0x3000 / instr 0x3C010001 with pop_ready = 1 -> with FETCH_BUF_BYPASS_EN: pop_valid = 1 same cycle, count stays 0; without: pop_valid = 1 next cycle, count = 1 after the push edge.
